// File: rtl/hazard_stall_ctrl_pkg.sv
// Opcode/funct constants, destination-select encodings and MD types
// shared by the stall controller and the MD busy FSM.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [1:0] A3_RD = 2'b00;
  localparam logic [1:0] A3_RT = 2'b01;
  localparam logic [1:0] A3_RS = 2'b10;
  localparam logic [1:0] A3_RA = 2'b11;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic logic [4:0] a3_dec(
    input logic [31:0] ir,
    input logic [1:0]  sel
  );
    logic [4:0] a3;
    a3 = ir[15:11];
    case (sel)
      A3_RD:   a3 = ir[15:11];
      A3_RT:   a3 = ir[20:16];
      A3_RS:   a3 = ir[25:21];
      default: a3 = 5'd31;
    endcase
    return a3;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_fsm.sv
// IDLE/BUSY sequencer for the shared HI/LO multiply/divide unit:
// loads the busy count on start and flags the final busy cycle.
module md_busy_fsm
  import mips_defs::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o,
  output logic done_o
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = is_div_i ? DIV_LD : MULT_LD;
        end
      end
      MD_BUSY: begin
        busy_o = 1'b1;
        if (cnt_q == 4'd1) begin
          done_o  = 1'b1;
          state_d = MD_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline freeze decisions the forwarding network cannot resolve:
// load-use, branch operands in D, and HI/LO unit occupancy.
module hazard_stall_ctrl
  import mips_defs::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] IR_M,
  input  logic        RWE_E,
  input  logic        RWE_M,
  input  logic [1:0]  A3sel_E,
  input  logic [1:0]  A3sel_M,
  output logic        stall,
  output logic        en_PC,
  output logic        en_D,
  output logic        clr_E,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cnt
);

  logic [5:0] op_d, op_e, op_m, fn_d, fn_e;
  logic [4:0] rs_d, rt_d, a3_e, a3_m;
  logic       is_mfx_d, use_rs, use_rt, is_br_d;
  logic       dst_e_ok, dst_m_ok, hit_e, br_hit_e, br_hit_m;
  logic       load_use, br_e, br_m, md_d, md_e, md_use;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic       unused_ir;

  assign op_d = IR_D[31:26];
  assign op_e = IR_E[31:26];
  assign op_m = IR_M[31:26];
  assign fn_d = IR_D[5:0];
  assign fn_e = IR_E[5:0];
  assign rs_d = IR_D[25:21];
  assign rt_d = IR_D[20:16];

  assign unused_ir = ^{IR_D[15:6], IR_E[10:6], IR_M[10:0]};

  assign is_mfx_d = (op_d == OP_RTYPE) &&
                    (fn_d == FN_MFHI || fn_d == FN_MFLO);
  assign use_rs = !(op_d == OP_J || op_d == OP_JAL ||
                    op_d == OP_LUI || is_mfx_d);
  assign use_rt = op_d == OP_RTYPE || op_d == OP_BEQ ||
                  op_d == OP_BNE || op_d == OP_SW;
  assign is_br_d = op_d == OP_BEQ || op_d == OP_BNE;

  // A3 == 0 marks "no destination", so $0 sources never match.
  assign a3_e     = a3_dec(IR_E, A3sel_E);
  assign a3_m     = a3_dec(IR_M, A3sel_M);
  assign dst_e_ok = RWE_E && (a3_e != 5'd0);
  assign dst_m_ok = RWE_M && (a3_m != 5'd0);

  assign hit_e = dst_e_ok &&
                 ((use_rs && rs_d == a3_e) ||
                  (use_rt && rt_d == a3_e));
  assign br_hit_e = dst_e_ok && (rs_d == a3_e || rt_d == a3_e);
  assign br_hit_m = dst_m_ok && (rs_d == a3_m || rt_d == a3_m);

  assign load_use = (op_e == OP_LW) && hit_e;
  assign br_e     = is_br_d && br_hit_e;
  assign br_m     = is_br_d && (op_m == OP_LW) && br_hit_m;

  assign md_d = (op_d == OP_RTYPE) &&
                (fn_d[5:2] == 4'b0100 || fn_d[5:2] == 4'b0110);
  assign md_e = (op_e == OP_RTYPE) && (fn_e[5:2] == 4'b0110);

  assign md_start = reset_n && md_e && !md_busy;
  assign md_op    = fn_e[1:0];
  assign md_use   = md_d && (md_busy || md_start);

  assign stall = load_use || br_e || br_m || md_use;
  assign en_PC = ~stall;
  assign en_D  = ~stall;
  assign clr_E = stall;

  md_busy_fsm #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_fsm (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (md_start),
    .is_div_i(fn_e[1]),
    .busy_o  (md_busy),
    .done_o  (md_done)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= 16'd0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, branch, MD
// sequencing, reset abort and stall counter saturation.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] IR_D, IR_E, IR_M;
  logic        RWE_E, RWE_M;
  logic [1:0]  A3sel_E, A3sel_M;
  logic        stall, en_PC, en_D, clr_E;
  logic        md_start, md_busy, md_done;
  logic [1:0]  md_op;
  logic [15:0] stall_cnt;

  int errs = 0;
  int checks = 0;

  localparam logic [31:0] LW8    = {6'b100011, 5'd0, 5'd8, 16'd0};
  localparam logic [31:0] LW5    = {6'b100011, 5'd0, 5'd5, 16'd0};
  localparam logic [31:0] LW6    = {6'b100011, 5'd0, 5'd6, 16'd0};
  localparam logic [31:0] LW0    = {6'b100011, 5'd0, 5'd0, 16'd0};
  localparam logic [31:0] ADD981 = {6'd0, 5'd8, 5'd1, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] ADD901 = {6'd0, 5'd0, 5'd1, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] ADD900 = {6'd0, 5'd0, 5'd0, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] ADD951 = {6'd0, 5'd5, 5'd1, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] SW8    = {6'b101011, 5'd1, 5'd8, 16'd0};
  localparam logic [31:0] ADDU5  = {6'd0, 5'd1, 5'd2, 5'd5, 5'd0, 6'h21};
  localparam logic [31:0] ADDU6  = {6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'h21};
  localparam logic [31:0] BEQ56  = {6'b000100, 5'd5, 5'd6, 16'd0};
  localparam logic [31:0] BNE75  = {6'b000101, 5'd7, 5'd5, 16'd0};
  localparam logic [31:0] BEQ310 = {6'b000100, 5'd31, 5'd0, 16'd0};
  localparam logic [31:0] JAL    = {6'b000011, 26'h40};
  localparam logic [31:0] MULT   = {6'd0, 5'd2, 5'd3, 10'd0, 6'h18};
  localparam logic [31:0] DIV    = {6'd0, 5'd2, 5'd3, 10'd0, 6'h1A};
  localparam logic [31:0] DIVU   = {6'd0, 5'd2, 5'd3, 10'd0, 6'h1B};
  localparam logic [31:0] MFLO   = {6'd0, 10'd0, 5'd4, 5'd0, 6'h12};

  always #10 clk = ~clk;

  hazard_stall_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .IR_D     (IR_D),
    .IR_E     (IR_E),
    .IR_M     (IR_M),
    .RWE_E    (RWE_E),
    .RWE_M    (RWE_M),
    .A3sel_E  (A3sel_E),
    .A3sel_M  (A3sel_M),
    .stall    (stall),
    .en_PC    (en_PC),
    .en_D     (en_D),
    .clr_E    (clr_E),
    .md_start (md_start),
    .md_op    (md_op),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    IR_D = '0; IR_E = '0; IR_M = '0;
    RWE_E = 1'b0; RWE_M = 1'b0;
    A3sel_E = 2'b00; A3sel_M = 2'b00;
  endtask

  task automatic do_reset();
    clear_in();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    IR_D = $urandom; IR_E = $urandom; IR_M = $urandom;
    RWE_E = 1'b1; RWE_M = 1'b1;
    A3sel_E = 2'($urandom_range(3)); A3sel_M = 2'($urandom_range(3));
    #1;
    checks++;
    if (md_busy !== 1'b0 || md_done !== 1'b0 || md_start !== 1'b0) begin
      errs++;
      $display("FAIL rst_md busy=%b done=%b start=%b want 000",
               md_busy, md_done, md_start);
    end
    tick();
    checks++;
    if (stall_cnt !== 16'd0) begin
      errs++;
      $display("FAIL rst_cnt got %0h want 0", stall_cnt);
    end
    clear_in();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({stall, en_PC, en_D, clr_E} !== 4'b0110) begin
        errs++;
        $display("FAIL nop_flags cyc%0d got %b want 0110", k,
                 {stall, en_PC, en_D, clr_E});
      end
    end
  endtask

  task automatic test_load_use();
    tick();
    do_reset();
    IR_E = LW8; RWE_E = 1'b1; A3sel_E = 2'b01; IR_D = ADD981;
    #1;
    checks++;
    if ({stall, clr_E, en_PC, en_D} !== 4'b1100) begin
      errs++;
      $display("FAIL lu_stall got %b want 1100",
               {stall, clr_E, en_PC, en_D});
    end
    tick();
    checks++;
    if (stall_cnt !== 16'd1) begin
      errs++;
      $display("FAIL lu_cnt got %0d want 1", stall_cnt);
    end
    IR_D = ADD901;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errs++;
      $display("FAIL lu_norm got %b want 0", stall);
    end
    IR_D = SW8;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errs++;
      $display("FAIL lu_sw_rt got %b want 1", stall);
    end
    IR_E = LW0; IR_D = ADD900;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errs++;
      $display("FAIL lu_r0 got %b want 0", stall);
    end
    IR_E = LW5; IR_D = BEQ56;
    IR_M = LW6; RWE_M = 1'b1; A3sel_M = 2'b01;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errs++;
      $display("FAIL multi_src got %b want 1", stall);
    end
    tick();
    checks++;
    if (stall_cnt !== 16'd2) begin
      errs++;
      $display("FAIL multi_cnt got %0d want 2", stall_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    IR_E = ADDU5; RWE_E = 1'b1; A3sel_E = 2'b00; IR_D = ADD951;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errs++;
      $display("FAIL alu_fwd got %b want 0", stall);
    end
    IR_D = BEQ56;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errs++;
      $display("FAIL br_e got %b want 1", stall);
    end
    tick();
    IR_E = '0; RWE_E = 1'b0;
    IR_M = LW6; RWE_M = 1'b1; A3sel_M = 2'b01;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errs++;
      $display("FAIL br_m got %b want 1", stall);
    end
    IR_M = ADDU6; A3sel_M = 2'b00;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errs++;
      $display("FAIL br_m_alu got %b want 0", stall);
    end
    tick();
    IR_M = '0; RWE_M = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errs++;
      $display("FAIL br_clear got %b want 0", stall);
    end
    IR_E = ADDU5; RWE_E = 1'b1; A3sel_E = 2'b00; IR_D = BNE75;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errs++;
      $display("FAIL bne_rt got %b want 1", stall);
    end
    IR_E = JAL; A3sel_E = 2'b11; IR_D = BEQ310;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errs++;
      $display("FAIL br_ra got %b want 1", stall);
    end
    tick();
  endtask

  task automatic test_mult();
    do_reset();
    IR_E = MULT; IR_D = MFLO;
    #1;
    checks++;
    if ({md_start, md_op, md_busy, stall} !== 5'b10001) begin
      errs++;
      $display("FAIL mult_t got %b want 10001",
               {md_start, md_op, md_busy, stall});
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      IR_E = (k == 2) ? MULT : '0;
      #1;
      checks++;
      if (md_busy !== (k <= 5) || md_done !== (k == 5) ||
          stall !== (k <= 5) || md_start !== 1'b0) begin
        errs++;
        $display("FAIL mult_t+%0d busy=%b done=%b stall=%b start=%b",
                 k, md_busy, md_done, stall, md_start);
      end
    end
  endtask

  task automatic test_divide();
    do_reset();
    IR_E = DIV;
    #1;
    checks++;
    if (md_start !== 1'b1 || md_op !== 2'b10) begin
      errs++;
      $display("FAIL div_start got %b/%b want 1/10", md_start, md_op);
    end
    for (int k = 1; k <= 11; k++) begin
      tick();
      IR_E = '0;
      #1;
      checks++;
      if (md_busy !== (k <= 10) || md_done !== (k == 10)) begin
        errs++;
        $display("FAIL div_t+%0d busy=%b done=%b", k, md_busy, md_done);
      end
    end
    IR_E = DIVU;
    #1;
    checks++;
    if (md_start !== 1'b1 || md_op !== 2'b11) begin
      errs++;
      $display("FAIL divu_start got %b/%b want 1/11", md_start, md_op);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      IR_E = '0;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (md_busy !== 1'b0 || md_done !== 1'b0) begin
      errs++;
      $display("FAIL abort got busy=%b done=%b want 00", md_busy, md_done);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (md_busy !== 1'b0 || md_done !== 1'b0) begin
        errs++;
        $display("FAIL post_abort cyc%0d busy=%b done=%b",
                 k, md_busy, md_done);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    IR_E = LW8; RWE_E = 1'b1; A3sel_E = 2'b01; IR_D = ADD981;
    repeat (65534) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFE) begin
      errs++;
      $display("FAIL sat_pre got %h want fffe", stall_cnt);
    end
    repeat (4000) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errs++;
      $display("FAIL sat_hold got %h want ffff", stall_cnt);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    clear_in();
    test_reset();
    test_load_use();
    test_branch();
    test_mult();
    test_divide();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline stall and multiply/divide scheduler for the 5-stage MIPS core. It owns the pipeline-freeze decisions that forwarding cannot cover:
- load-use hazards;
- branch-operand hazards in D;
- access to the shared HI/LO multiply/divide unit, which stays busy for several cycles.

It sits beside the forwarding unit, drives PC/IF-ID enables and the ID/EX clear, and sequences the MD unit.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (2..15)
- DIV_CYCLES, 10, busy cycles for div/divu (2..15)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- IR_D, IR_E, IR_M  in  32 each  instruction registers of D, E and M
- RWE_E, RWE_M  in  1 each  register-write enable of the E and M instruction
- A3sel_E, A3sel_M  in  2 each  destination select: 00 Rd, 01 Rt, 10 Rs, 11 $31
- stall  out  1  combinational; hazard present this cycle
- en_PC, en_D  out  1 each  = ~stall
- clr_E  out  1  = stall; inserts a bubble into ID/EX
- md_start  out  1  one-cycle pulse launching the MD unit
- md_op  out  2  00 mult, 01 multu, 10 div, 11 divu; valid with md_start
- md_busy  out  1  MD unit occupied
- md_done  out  1  pulse in the final busy cycle
- stall_cnt  out  16  saturating count of stalled cycles

## Operation
Source operands read by IR_D:
- rs: every instruction except j/jal/lui/mfhi/mflo.
- rt: R-type, beq, bne, sw.
- Register $0 never causes a hazard.

Destination:
- A3_E and A3_M are decoded from A3sel as in the forwarding unit.
- A destination is valid only when its RWE is set and A3 ≠ 0.

Stall sources; stall is the OR of all four:
- **load_use:** IR_E is lw (op 100011), and its valid destination equals a D source.
- **br_E:** IR_D is beq/bne, and the valid destination of IR_E equals rs or rt of IR_D.
- **br_M:** IR_D is beq/bne, IR_M is lw, and its valid destination equals rs or rt of IR_D.
- **md_use:** IR_D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo, and (md_busy or md_start) is set.

MD FSM:
- States IDLE and BUSY, with a 4-bit cnt.
- **md_start:** asserted when IR_E is R-type with funct 011000/011001/011010/011011 and the FSM is IDLE.
  - md_op = funct[1:0].
  - Next edge: cnt ← MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu); state → BUSY.
- **BUSY:**
  - cnt decrements each edge.
  - md_busy = (state == BUSY).
  - md_done = BUSY && cnt == 1.
  - On the edge where cnt == 1: cnt → 0, state → IDLE.
- An MD instruction cannot reach E while BUSY, because md_use holds it in D. If one arrives in E anyway (illegal), md_start stays 0 and the state is unchanged.

stall_cnt:
- Increments on every edge where stall = 1.
- Saturates at 16'hFFFF.

## Timing
- Reset (asynchronous, reset_n low): state IDLE, cnt 0, stall_cnt 0, md_busy 0, md_done 0, md_start 0.
- With all IRs at 0 (nop), stall = 0, en_PC = en_D = 1, clr_E = 0.
- stall, en_PC, en_D, clr_E and md_start are combinational from the inputs and current state: zero latency.
- mult launched in E in cycle t:
  - md_busy high in cycles t+1 .. t+MULT_CYCLES.
  - md_done high in cycle t+MULT_CYCLES.
  - An mflo waiting in D is stalled through t+MULT_CYCLES and leaves D in t+MULT_CYCLES+1.
- Simultaneous stall sources give a single stall; stall_cnt increments by 1.
- reset_n asserted mid-BUSY aborts immediately to IDLE. No md_done is produced.
- An MD instruction arriving in D in the same cycle as md_done still stalls that cycle, because md_busy = 1.

## Structure
- Shared package `mips_defs`: opcode/funct constants (OP_LW, OP_BEQ, OP_BNE, FN_MULT..FN_MTLO), A3sel encodings, the md_op encoding, and the FSM state typedef.
- One natural sub-module, `md_busy_fsm`: the IDLE/BUSY FSM, cnt and md_done.
- Hazard comparison logic and stall_cnt stay in the top level.

## Test plan
- **Reset:** reset_n=0 with random IRs → md_busy=0, stall_cnt=0. Release with nops → stall=0 every cycle.
- **Load-use:** IR_E = lw $8,0($0) (RWE_E=1, A3sel_E=01), IR_D = add $9,$8,$1 → stall=1, clr_E=1, en_PC=0. With IR_D = add $9,$0,$1 → stall=0.
- **Branch in D:**
  - IR_E = addu $5 (A3sel_E=00, RWE_E=1) and IR_D = beq $5,$6 → stall=1.
  - Next cycle, IR_M = lw $6, IR_E = nop → stall=1 (br_M).
  - Then stall=0.
- **Multiply:** mult in E at t → md_start=1, md_op=00. mflo in D stalls for t..t+5, md_done at t+5, released at t+6.
- **Divide, then reset:** divu in E → md_op=11, busy for 10 cycles. reset_n pulsed at busy cycle 4 → md_busy=0 immediately, no md_done.
- **Counter saturation:** force 70000 stall cycles → stall_cnt holds at 16'hFFFF.
